result_collector_fpga: RTL and testbench
========================================

// Module: result_collector_fpga
// PURPOSE
// - Initiator side of the start/done handshake: issues the start pulse to the shift-in/shift-out controller, then consumes its output.
// - Deserializes the serial result bits strobed by enC into one RES_W word.
// - Hands the word downstream on a valid/ready port.
// - Sits between the job source and the controller/datapath pair; one job in flight at a time.
// PARAMETERS
// RES_W    16    result width in bits; bits are collected MSB-first
// TMO      1023  max cycles from start pulse to done before timeout
// TMO_W    10    timeout counter width (TMO must be < 2**TMO_W)
// PORTS
// clk        in   1      rising-edge clock, single domain
// rst        in   1      asynchronous, active-low reset
// req_valid  in   1      job request from upstream
// req_ready  out  1      1 only in IDLE; job accepted when req_valid&req_ready
// start      out  1      start to controller; exactly one-cycle pulse per job
// enC        in   1      serial-bit strobe from controller (shift_out phase)
// ser_bit    in   1      serial result bit, sampled when enC=1
// done       in   1      job-complete level from controller
// res_data   out  RES_W  collected word, stable while res_valid=1
// res_valid  out  1      result available
// res_ready  in   1      downstream accepts when res_valid&res_ready
// res_ovf    out  1      more than RES_W bits seen this job
// res_tmo    out  1      job ended by timeout, not done
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, start=0, res_valid=0, res_data=0, res_ovf=0, res_tmo=0, bit count=0, timeout count=0.
// - States: IDLE, PULSE, RUN, PRESENT.
// - IDLE: req_ready=1. On req_valid, go to PULSE and clear res_data, bit count, flags and timeout count.
// - PULSE: start=1 for this one cycle only, then go to RUN. start is registered: high exactly the cycle after acceptance.
// - RUN: timeout counter increments every cycle.
//   - enC=1: res_data <= {res_data[RES_W-2:0], ser_bit}; bit count increments, saturating at RES_W.
//   - enC=1 while count==RES_W: still shift (keep the last RES_W bits) and set res_ovf (sticky for the job).
//   - done=1: go to PRESENT. If enC=1 in the same cycle, that bit is captured first.
//   - Timeout counter reaches TMO with done=0: set res_tmo and go to PRESENT. res_data holds whatever was collected.
// - PRESENT: res_valid=1; res_data and flags are frozen and enC is ignored.
//   - res_ready=1: go to IDLE. res_valid drops the next cycle; res_data and flags hold until the next job is accepted.
//   - done still high on return to IDLE has no effect; only req_valid starts a job.
// - Latency: acceptance to start = 1 cycle. done to res_valid = 1 cycle. Zero-wait res_ready gives back-to-back jobs of at least 4 cycles.
// - Fewer than RES_W bits collected: the word is right-aligned, upper bits 0.
// - Reset mid-operation: start drops immediately (async) and any partial word is discarded.
// - req_ready=0 outside IDLE; requests then are not accepted and not buffered.
// STRUCTURE
// - Shared package: state encoding localparams (IDLE=2'd0, PULSE=2'd1, RUN=2'd2, PRESENT=2'd3).
// - One sub-module: shift_collector (RES_W shift register, saturating bit counter, ovf flag).
//   - Ports: clk, rst, clr, en, bit_in, data, cnt, ovf.
// - Top level: state register, timeout counter, output decode.
// TESTING
// - Nominal: RES_W=16; req pulse; 16 enC strobes carrying 0xA5C3 MSB-first, then done -> start high for 1 cycle; res_data=0xA5C3, res_valid=1, res_ovf=0, res_tmo=0.
// - Short word: 4 bits 1,0,1,1 then done -> res_data=0x000B.
// - Overflow: 18 strobes carrying 0x3FFFE -> res_data=0xFFFE, res_ovf=1.
// - Timeout: TMO=20, no done -> res_valid rises 21 cycles after start, res_tmo=1.
// - Backpressure and edge: res_ready=0 for 5 cycles -> res_valid and res_data stable, req_ready=0 throughout.
//   - enC and done in the same cycle -> last bit captured.
// - Reset mid-RUN after 7 bits -> start=0, res_valid=0, res_data=0 immediately.
//   - Next job collects from an empty word.

Source files
------------

// File: rtl/result_collector_fpga_pkg.sv
// Shared definitions for the result collector: FSM state encoding and a
// helper that sizes the saturating bit counter.
package result_collector_fpga_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE   = 2'd1,
      RUN     = 2'd2,
      PRESENT = 2'd3
   } state_e;

   // Bits needed to hold a count from 0 up to and including w.
   function automatic int cnt_bits(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/result_collector_fpga_shift_collector.sv
// MSB-first deserializer: shifts bit_in into an RES_W-bit word on every
// enable, counts bits up to RES_W and raises a sticky overflow flag when a
// further bit arrives once the word is already full.
module result_collector_fpga_shift_collector
   import result_collector_fpga_pkg::*;
#(
   parameter int RES_W = 16,
   parameter int CNT_W = cnt_bits(RES_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [RES_W-1:0] data,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic [RES_W-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // Next-state: clear wins over shift; past RES_W bits the oldest bit falls off.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
      end else if (en) begin
         data_d = {data_q[RES_W-2:0], bit_in};
         if (cnt_q == CNT_W'(RES_W)) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Collector state registers; rst is active low and asynchronous.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign data = data_q;
   assign cnt  = cnt_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/result_collector_fpga.sv
// Job initiator and result collector: accepts one job at a time, pulses
// start to the controller, deserializes the enC-strobed result bits, and
// presents the word on a valid/ready port with overflow and timeout flags.
module result_collector_fpga
   import result_collector_fpga_pkg::*;
#(
   parameter int RES_W = 16,
   parameter int TMO   = 1023,
   parameter int TMO_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   output logic             start,
   input  logic             enC,
   input  logic             ser_bit,
   input  logic             done,
   output logic [RES_W-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_ovf,
   output logic             res_tmo
);

   localparam int CNT_W = cnt_bits(RES_W);

   state_e           state_q, state_d;
   logic             start_q, start_d;
   logic             res_valid_q, res_valid_d;
   logic             res_tmo_q, res_tmo_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic             accept;
   logic             shift_en;
   logic [CNT_W-1:0] bit_cnt_unused;

   // A job is taken only while idle; the word is cleared on the same edge.
   assign accept   = (state_q == IDLE) && req_valid;
   // Bits are only taken while the job runs; PRESENT freezes the word.
   assign shift_en = (state_q == RUN) && enC;

   result_collector_fpga_shift_collector #(
      .RES_W (RES_W),
      .CNT_W (CNT_W)
   ) u_shift (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (shift_en),
      .bit_in (ser_bit),
      .data   (res_data),
      .cnt    (bit_cnt_unused),
      .ovf    (res_ovf)
   );

   // FSM next-state and registered output decode; done outranks timeout.
   always_comb begin
      state_d     = state_q;
      start_d     = 1'b0;
      res_valid_d = res_valid_q;
      res_tmo_d   = res_tmo_q;
      tmo_d       = tmo_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d   = PULSE;
               start_d   = 1'b1;
               res_tmo_d = 1'b0;
               tmo_d     = '0;
            end
         end
         PULSE: begin
            state_d = RUN;
         end
         RUN: begin
            tmo_d = tmo_q + 1'b1;
            if (done) begin
               state_d     = PRESENT;
               res_valid_d = 1'b1;
            end else if (tmo_q == TMO_W'(TMO - 1)) begin
               // Counter reaches TMO on this edge with no done seen.
               state_d     = PRESENT;
               res_valid_d = 1'b1;
               res_tmo_d   = 1'b1;
            end
         end
         PRESENT: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers; an asynchronous reset drops start at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_tmo_q   <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         res_valid_q <= res_valid_d;
         res_tmo_q   <= res_tmo_d;
         tmo_q       <= tmo_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign start     = start_q;
   assign res_valid = res_valid_q;
   assign res_tmo   = res_tmo_q;

endmodule

// File: tb/tb_result_collector_fpga.sv
// Scoreboard bench for result_collector_fpga: jobs are issued with random
// bit streams, the expected word/flags are pushed to a queue, and a monitor
// pops and compares whenever a result is handed off.
module tb_result_collector_fpga;

   localparam int RES_W = 16;
   localparam int TMO   = 20;
   localparam int TMO_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             start;
   logic             enC = 1'b0;
   logic             ser_bit = 1'b0;
   logic             done = 1'b0;
   logic [RES_W-1:0] res_data;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic             res_ovf;
   logic             res_tmo;

   typedef struct {
      logic [15:0] d;
      bit          ovf;
      bit          tmo;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   start_cyc;

   result_collector_fpga #(
      .RES_W (RES_W),
      .TMO   (TMO),
      .TMO_W (TMO_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .start     (start),
      .enC       (enC),
      .ser_bit   (ser_bit),
      .done      (done),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_ovf   (res_ovf),
      .res_tmo   (res_tmo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: the last RES_W bits of an n-bit MSB-first stream, right-aligned.
   function automatic logic [15:0] model(input logic [31:0] v, input int n);
      int unsigned w = 0;
      for (int i = n - 1; i >= 0; i--) begin
         w = ((w << 1) | 32'(v[i])) & 32'hFFFF;
      end
      return w[15:0];
   endfunction

   // Monitor: each handoff pops one expected result.
   always @(negedge clk) begin
      if (rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'(res_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_data", 32'(res_data), 32'(e.d));
            check("res_ovf", 32'(res_ovf), 32'(e.ovf));
            check("res_tmo", 32'(res_tmo), 32'(e.tmo));
            $display("result data=%04h ovf=%0d tmo=%0d", res_data, res_ovf, res_tmo);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int s = 0;
      while (!req_ready && s < 50) begin
         tick();
         s++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
   endtask

   task automatic run_job(input logic [31:0] val, input int n, input bit to,
                          input bit merge, input int max_gap, input int bp);
      exp_t        e;
      int          used;
      int          g;
      int          s;
      int          extra;
      logic [15:0] held;
      e.d   = model(val, n);
      e.ovf = (n > RES_W);
      e.tmo = to;
      extra = (merge || to) ? 0 : 1;
      wait_idle();
      sb.push_back(e);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("start_pulse", 32'(start), 32'd1);
      start_cyc = cyc;
      tick();
      check("start_one_cycle", 32'(start), 32'd0);
      used = 1;
      for (int i = 0; i < n; i++) begin
         enC       = 1'b1;
         ser_bit   = val[n-1-i];
         done      = merge && !to && (i == n - 1);
         req_valid = 1'($urandom_range(0, 1));
         tick();
         used++;
         enC       = 1'b0;
         done      = 1'b0;
         if (max_gap > 0) begin
            g = $urandom_range(0, max_gap);
            if (used + g + (n - 1 - i) + extra > 20) g = 0;
            repeat (g) begin
               tick();
               used++;
            end
         end
      end
      check("req_ignored_busy", 32'(start), 32'd0);
      req_valid = 1'b0;
      if (!to && !merge) begin
         done = 1'b1;
         tick();
         done = 1'b0;
      end
      if (to) begin
         s = 0;
         while (!res_valid && s < 40) begin
            tick();
            s++;
         end
         check("tmo_latency", 32'(cyc - start_cyc), 32'd21);
      end else begin
         check("done_to_valid", 32'(res_valid), 32'd1);
      end
      held = res_data;
      for (int k = 0; k < bp; k++) begin
         enC     = 1'($urandom_range(0, 1));
         ser_bit = 1'($urandom_range(0, 1));
         done    = 1'($urandom_range(0, 1));
         tick();
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_data_stable", 32'(res_data), 32'(held));
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      enC       = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("valid_drop", 32'(res_valid), 32'd0);
      check("req_ready_back", 32'(req_ready), 32'd1);
      check("data_hold", 32'(res_data), 32'(held));
      tick();
      done = 1'b0;
      check("no_spurious_start", 32'(start), 32'd0);
      $display("job n=%0d val=%0h to=%0d merge=%0d bp=%0d exp=%04h", n, val, to, merge, bp, e.d);
   endtask

   task automatic reset_mid(input int nbits);
      wait_idle();
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("rst_pre_start", 32'(start), 32'd1);
      if (nbits > 0) begin
         tick();
         for (int i = 0; i < nbits; i++) begin
            enC     = 1'b1;
            ser_bit = 1'b1;
            tick();
         end
         enC = 1'b0;
      end
      rst = 1'b0;
      #1;
      check("rst_start", 32'(start), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_data", 32'(res_data), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      tick();
      rst = 1'b1;
      $display("reset mid-job after %0d bits", nbits);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit to;
      repeat (3) tick();
      check("reset_start", 32'(start), 32'd0);
      check("reset_valid", 32'(res_valid), 32'd0);
      check("reset_data", 32'(res_data), 32'd0);
      check("reset_ovf", 32'(res_ovf), 32'd0);
      check("reset_tmo", 32'(res_tmo), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b1;
      tick();

      run_job(32'h0000A5C3, 16, 1'b0, 1'b0, 0, 0);   // nominal
      run_job(32'h0000000B, 4, 1'b0, 1'b0, 0, 0);    // short word
      run_job(32'h0003FFFE, 18, 1'b0, 1'b0, 0, 0);   // overflow
      run_job(32'h00000015, 5, 1'b1, 1'b0, 0, 0);    // timeout
      run_job(32'h00001234, 16, 1'b0, 1'b1, 0, 5);   // same-cycle done, backpressure
      reset_mid(0);
      reset_mid(7);
      run_job(32'h0000000B, 4, 1'b0, 1'b0, 0, 0);    // fresh word after reset

      for (int j = 0; j < 30; j++) begin
         to = ($urandom_range(0, 5) == 0);
         n  = to ? $urandom_range(1, 15) : $urandom_range(1, 18);
         run_job($urandom, n, to, 1'($urandom_range(0, 1)),
                 (n <= 12) ? 2 : 0, $urandom_range(0, 3));
      end

      repeat (3) tick();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
